// File: rtl/gd_sequencer_if.sv
// rtl/gd_sequencer_if.sv - configuration, serial input, dataset memory and datapath strobe bundle for gd_sequencer
interface gd_sequencer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int LENGTH     = 16
);
    logic                  S;
    logic [3:0]            feat;
    logic [7:0]            epoch;
    logic [ADDR_WIDTH-1:0] data_points;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [3:0]            wr_col;
    logic [LENGTH-1:0]     wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [3:0]            rd_col;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  err_en;
    logic                  upd_en;
    logic [3:0]            stb_col;
    logic [7:0]            epoch_cnt;
    logic                  done_;

    modport master (
        input  S, feat, epoch, data_points,
        output wr_en, wr_addr, wr_col, wr_data, rd_en, rd_addr, rd_col,
               mac_clr, mac_en, err_en, upd_en, stb_col, epoch_cnt, done_
    );

    modport slave (
        output S, feat, epoch, data_points,
        input  wr_en, wr_addr, wr_col, wr_data, rd_en, rd_addr, rd_col,
               mac_clr, mac_en, err_en, upd_en, stb_col, epoch_cnt, done_
    );
endinterface

// File: rtl/gd_sequencer.sv
// rtl/gd_sequencer.sv - loads the serial training set into memory, then sequences epoch passes of predict/error/update reads and strobes
module gd_sequencer #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DP_LAT       = 2
) (
    input  logic           CLK,
    input  logic           RST,
    gd_sequencer_if.master bus
);
    localparam int COL_W = $clog2(MAX_FEATURES + 1);
    localparam int BIT_W = $clog2(LENGTH);

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_MAC  = 2'd1;
    localparam logic [1:0] PH_ERR  = 2'd2;
    localparam logic [1:0] PH_UPD  = 2'd3;

    typedef enum logic [3:0] {
        S_LOAD, S_CLR, S_PRED, S_YRD, S_WAIT, S_UPD, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      cfg_feat_q;
    logic [7:0]            cfg_epoch_q;
    logic [ADDR_WIDTH-1:0] cfg_dp_q;

    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [2:0]            wait_q, wait_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [LENGTH-1:0]     sh_q, sh_d;
    logic [7:0]            ep_cnt_q, ep_cnt_d;
    logic                  last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [COL_W-1:0]      wr_col_q, wr_col_d;
    logic [LENGTH-1:0]     wr_data_q, wr_data_d;
    logic [COL_W+1:0]      pipe_q [DP_LAT];
    logic [COL_W+1:0]      pipe_d [DP_LAT];

    logic                  rd_en_c;
    logic [COL_W-1:0]      rd_col_c;
    logic [1:0]            phase_c;
    logic [1:0]            out_phase;

    // Read issue and its phase tag are decoded straight from the state so the tag enters the pipe with the read.
    always_comb begin
        rd_en_c  = 1'b0;
        rd_col_c = '0;
        phase_c  = PH_NONE;
        case (state_q)
            S_PRED: begin rd_en_c = 1'b1; rd_col_c = col_q; phase_c = PH_MAC; end
            S_YRD:  begin rd_en_c = 1'b1; phase_c = PH_ERR; end
            S_UPD:  begin rd_en_c = 1'b1; rd_col_c = col_q; phase_c = PH_UPD; end
            default: ;
        endcase
        pipe_d[0] = {phase_c, rd_col_c};
        for (int i = 1; i < DP_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        wait_d    = wait_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        ep_cnt_d  = ep_cnt_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_LOAD: begin
                if (last_q) begin
                    // The final write is on the bus this cycle; training starts on the next one.
                    last_d  = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = (cfg_epoch_q == 8'd0) ? S_DONE : S_CLR;
                end else begin
                    sh_d  = {bus.S, sh_q[LENGTH-1:1]};
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(LENGTH - 1)) begin
                        bit_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = sh_d;
                        wr_addr_d = row_q;
                        wr_col_d  = cfg_feat_q - col_q;
                        if (col_q == cfg_feat_q) begin
                            col_d = '0;
                            if (row_q == cfg_dp_q) last_d = 1'b1;
                            else                   row_d  = row_q + ADDR_WIDTH'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end
            S_CLR: begin
                col_d   = COL_W'(1);
                state_d = (cfg_feat_q == '0) ? S_YRD : S_PRED;
            end
            S_PRED: begin
                if (col_q == cfg_feat_q) state_d = S_YRD;
                else                     col_d   = col_q + COL_W'(1);
            end
            S_YRD: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 3'(DP_LAT - 1)) begin
                    wait_d  = '0;
                    col_d   = COL_W'(1);
                    state_d = (cfg_feat_q == '0) ? S_DRAIN : S_UPD;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_UPD: begin
                if (col_q == cfg_feat_q) begin
                    wait_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_DRAIN: begin
                if (wait_q == 3'(DP_LAT - 1)) state_d = S_NEXT;
                else                          wait_d  = wait_q + 3'd1;
            end
            S_NEXT: begin
                state_d = S_CLR;
                if (row_q == cfg_dp_q) begin
                    row_d    = '0;
                    ep_cnt_d = ep_cnt_q + 8'd1;
                    if (ep_cnt_d == cfg_epoch_q) state_d = S_DONE;
                end else begin
                    row_d = row_q + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_LOAD;
            cfg_feat_q  <= bus.feat;
            cfg_epoch_q <= bus.epoch;
            cfg_dp_q    <= bus.data_points;
            col_q       <= '0;
            row_q       <= '0;
            wait_q      <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            ep_cnt_q    <= '0;
            last_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
            for (int i = 0; i < DP_LAT; i++) pipe_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            ep_cnt_q  <= ep_cnt_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < DP_LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign out_phase     = (state_q == S_DONE) ? PH_NONE : pipe_q[DP_LAT-1][COL_W+1:COL_W];
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_col    = wr_col_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = rd_en_c ? row_q : '0;
    assign bus.rd_col    = rd_col_c;
    assign bus.mac_clr   = (state_q == S_CLR);
    assign bus.mac_en    = (out_phase == PH_MAC);
    assign bus.err_en    = (out_phase == PH_ERR);
    assign bus.upd_en    = (out_phase == PH_UPD);
    assign bus.stb_col   = (out_phase == PH_NONE) ? '0 : pipe_q[DP_LAT-1][COL_W-1:0];
    assign bus.epoch_cnt = ep_cnt_q;
    assign bus.done_     = (state_q == S_DONE);
endmodule

// File: tb/tb_gd_sequencer.sv
// tb/tb_gd_sequencer.sv - directed self-checking bench for gd_sequencer
module tb_gd_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gd_sequencer_if #(.ADDR_WIDTH(12), .LENGTH(16)) bus ();

    gd_sequencer #(
        .ADDR_WIDTH(12), .MAX_FEATURES(15), .LENGTH(16), .DP_LAT(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ld_word [6];
    logic [11:0] ld_addr [6];
    logic [3:0]  ld_col  [6];

    function automatic logic [77:0] all_outs();
        return {bus.wr_en, bus.wr_addr, bus.wr_col, bus.wr_data, bus.rd_en, bus.rd_addr,
                bus.rd_col, bus.mac_clr, bus.mac_en, bus.err_en, bus.upd_en, bus.stb_col,
                bus.epoch_cnt, bus.done_, 18'd0};
    endfunction

    function automatic logic [12:0] row_obs();
        return {bus.mac_clr, bus.rd_en, bus.rd_col, bus.mac_en, bus.err_en, bus.upd_en, bus.stb_col};
    endfunction

    // {mac_clr, rd_en, rd_col, mac_en, err_en, upd_en, stb_col} per row cycle, feat=2, DP_LAT=2
    function automatic logic [12:0] exp_f2(int k);
        case (k)
            0:       return {1'b1, 1'b0, 4'd0, 3'b000, 4'd0};
            1:       return {1'b0, 1'b1, 4'd1, 3'b000, 4'd0};
            2:       return {1'b0, 1'b1, 4'd2, 3'b000, 4'd0};
            3:       return {1'b0, 1'b1, 4'd0, 3'b100, 4'd1};
            4:       return {1'b0, 1'b0, 4'd0, 3'b100, 4'd2};
            5:       return {1'b0, 1'b0, 4'd0, 3'b010, 4'd0};
            6:       return {1'b0, 1'b1, 4'd1, 3'b000, 4'd0};
            7:       return {1'b0, 1'b1, 4'd2, 3'b000, 4'd0};
            8:       return {1'b0, 1'b0, 4'd0, 3'b001, 4'd1};
            9:       return {1'b0, 1'b0, 4'd0, 3'b001, 4'd2};
            default: return 13'd0;
        endcase
    endfunction

    // feat=0, DP_LAT=2: CLR, YRD, WAIT x2, DRAIN x2, NEXT
    function automatic logic [12:0] exp_f0(int k);
        case (k)
            0:       return {1'b1, 1'b0, 4'd0, 3'b000, 4'd0};
            1:       return {1'b0, 1'b1, 4'd0, 3'b000, 4'd0};
            3:       return {1'b0, 1'b0, 4'd0, 3'b010, 4'd0};
            default: return 13'd0;
        endcase
    endfunction

    task automatic set_f2_data();
        ld_word[0] = 16'h1234; ld_addr[0] = 12'd0; ld_col[0] = 4'd2;
        ld_word[1] = 16'hABCD; ld_addr[1] = 12'd0; ld_col[1] = 4'd1;
        ld_word[2] = 16'h0001; ld_addr[2] = 12'd0; ld_col[2] = 4'd0;
        ld_word[3] = 16'hFFFF; ld_addr[3] = 12'd1; ld_col[3] = 4'd2;
        ld_word[4] = 16'h8000; ld_addr[4] = 12'd1; ld_col[4] = 4'd1;
        ld_word[5] = 16'h0000; ld_addr[5] = 12'd1; ld_col[5] = 4'd0;
    endtask

    task automatic apply_reset(input logic [3:0] f, input logic [7:0] e, input logic [11:0] d, input int n);
        rst = 1'b1;
        bus.feat = f;
        bus.epoch = e;
        bus.data_points = d;
        repeat (n) begin
            bus.S = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic stream_load(input int nw);
        int pulses = 0;
        int last_t = 0;
        logic exp_wr;
        logic [15:0] w;
        for (int i = 0; i < nw * 16; i++) begin
            rst = 1'b0;
            w = ld_word[i / 16];
            bus.S = w[i % 16];
            @(negedge clk);
            exp_wr = ((i % 16) == 15);
            checks++;
            if (bus.wr_en !== exp_wr) begin
                errors++;
                $display("FAIL load_wr_en bit=%0d got %b exp %b", i, bus.wr_en, exp_wr);
            end
            checks++;
            if ((bus.rd_en | bus.mac_clr) !== 1'b0) begin
                errors++;
                $display("FAIL load_no_rd bit=%0d rd_en=%b mac_clr=%b exp 0", i, bus.rd_en, bus.mac_clr);
            end
            if (bus.wr_en === 1'b1 && pulses < nw) begin
                checks++;
                if ({bus.wr_addr, bus.wr_col, bus.wr_data} !== {ld_addr[pulses], ld_col[pulses], ld_word[pulses]}) begin
                    errors++;
                    $display("FAIL load_word %0d got (%0d,%0d,%h) exp (%0d,%0d,%h)", pulses,
                             bus.wr_addr, bus.wr_col, bus.wr_data, ld_addr[pulses], ld_col[pulses], ld_word[pulses]);
                end
                if (pulses > 0) begin
                    checks++;
                    if (i - last_t != 16) begin
                        errors++;
                        $display("FAIL load_spacing got %0d exp 16", i - last_t);
                    end
                end
                last_t = i;
                pulses++;
            end
        end
        checks++;
        if (pulses != nw) begin
            errors++;
            $display("FAIL load_pulse_count got %0d exp %0d", pulses, nw);
        end
    endtask

    task automatic test_reset();
        int wr_pulses = 0;
        rst = 1'b1;
        bus.feat = 4'd2;
        bus.epoch = 8'd3;
        bus.data_points = 12'd1;
        for (int i = 0; i < 10; i++) begin
            bus.S = 1'($urandom);
            @(negedge clk);
            if (bus.wr_en === 1'b1) wr_pulses++;
            checks++;
            if (all_outs() !== 78'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got %h exp 0", i, all_outs());
            end
        end
        checks++;
        if (wr_pulses != 0) begin
            errors++;
            $display("FAIL reset_wr_pulses got %0d exp 0", wr_pulses);
        end
    endtask

    task automatic test_load_train();
        set_f2_data();
        apply_reset(4'd2, 8'd3, 12'd1, 2);
        stream_load(6);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 11; k++) begin
                bus.S = 1'($urandom);
                @(negedge clk);
                checks++;
                if (row_obs() !== exp_f2(k)) begin
                    errors++;
                    $display("FAIL train_strobes row=%0d k=%0d got %b exp %b", r, k, row_obs(), exp_f2(k));
                end
                checks++;
                if ({bus.rd_addr, bus.epoch_cnt, bus.done_, bus.wr_en} !==
                    {(bus.rd_en ? 12'(r % 2) : 12'd0), 8'(r / 2), 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL train_counters row=%0d k=%0d got addr=%0d ep=%0d done=%b wr=%b exp addr=%0d ep=%0d",
                             r, k, bus.rd_addr, bus.epoch_cnt, bus.done_, bus.wr_en, r % 2, r / 2);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.done_, bus.epoch_cnt, row_obs()} !== {1'b1, 8'd3, 13'd0}) begin
                errors++;
                $display("FAIL train_done cycle=%0d got done=%b ep=%0d strobes=%b exp done=1 ep=3 strobes=0",
                         i, bus.done_, bus.epoch_cnt, row_obs());
            end
        end
    endtask

    task automatic test_feat0();
        ld_word[0] = 16'h5A3C; ld_addr[0] = 12'd0; ld_col[0] = 4'd0;
        apply_reset(4'd0, 8'd1, 12'd0, 2);
        stream_load(1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.done_, row_obs()} !== {1'b0, exp_f0(k)}) begin
                errors++;
                $display("FAIL feat0_row k=%0d got done=%b strobes=%b exp done=0 strobes=%b", k, bus.done_, row_obs(), exp_f0(k));
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.done_, bus.epoch_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL feat0_done got done=%b ep=%0d exp done=1 ep=1", bus.done_, bus.epoch_cnt);
        end
    endtask

    task automatic test_epoch0();
        ld_word[0] = 16'hC0DE; ld_addr[0] = 12'd0; ld_col[0] = 4'd1;
        ld_word[1] = 16'h0042; ld_addr[1] = 12'd0; ld_col[1] = 4'd0;
        apply_reset(4'd1, 8'd0, 12'd0, 2);
        stream_load(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.done_, bus.rd_en, bus.mac_clr} !== 3'b100) begin
                errors++;
                $display("FAIL epoch0_done cycle=%0d got done=%b rd_en=%b mac_clr=%b exp 1,0,0",
                         i, bus.done_, bus.rd_en, bus.mac_clr);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_f2_data();
        apply_reset(4'd2, 8'd3, 12'd1, 2);
        stream_load(6);
        for (int k = 0; k < 7; k++) @(negedge clk);
        checks++;
        if (row_obs() !== exp_f2(6)) begin
            errors++;
            $display("FAIL midrst_in_upd got %b exp %b", row_obs(), exp_f2(6));
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (all_outs() !== 78'd0) begin
                errors++;
                $display("FAIL midrst_outputs cycle=%0d got %h exp 0", i, all_outs());
            end
        end
        stream_load(6);
        @(negedge clk);
        checks++;
        if (row_obs() !== exp_f2(0)) begin
            errors++;
            $display("FAIL midrst_restart_clr got %b exp %b", row_obs(), exp_f2(0));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.S = 1'b0;
        bus.feat = 4'd0;
        bus.epoch = 8'd0;
        bus.data_points = 12'd0;
        test_reset();
        test_load_train();
        test_feat0();
        test_epoch0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
